// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state type and output saturation for the
// two-channel 5-tap FIR scheduler.
//   N_TAPS - taps per filter and history depth per channel
//   W      - sample / coefficient / output width (signed)
//   ACC_W  - accumulator width, sized so N_TAPS full-scale products never wrap
//   SHIFT  - default arithmetic right shift applied before saturation
package fir_pkg;

  localparam int N_TAPS = 5;
  localparam int W      = 8;
  localparam int ACC_W  = 2 * W + $clog2(N_TAPS);
  localparam int SHIFT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp an accumulator value into the signed W-bit output range.
  function automatic logic signed [W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[W-1:0];
    end else begin
      return v[W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_sched_if.sv
// fir_sched_if: all handshake, configuration and result signals of fir_sched.
//   ch0_valid/ch0_x/ch0_ready - channel 0 sample stream
//   ch1_valid/ch1_x/ch1_ready - channel 1 sample stream
//   cfg_we/cfg_addr/cfg_data  - coefficient bank write port
//   o_valid/o_ch/o_y          - one-cycle result strobe, its channel and value
//   busy                      - scheduler is not idle
// master: the sample source / configurator / result consumer side.
// slave:  the fir_sched side.
interface fir_sched_if;
  import fir_pkg::*;

  logic                ch0_valid;
  logic signed [W-1:0] ch0_x;
  logic                ch0_ready;
  logic                ch1_valid;
  logic signed [W-1:0] ch1_x;
  logic                ch1_ready;
  logic                cfg_we;
  logic [2:0]          cfg_addr;
  logic signed [W-1:0] cfg_data;
  logic                o_valid;
  logic                o_ch;
  logic signed [W-1:0] o_y;
  logic                busy;

  modport master (
    output ch0_valid, ch0_x, ch1_valid, ch1_x, cfg_we, cfg_addr, cfg_data,
    input  ch0_ready, ch1_ready, o_valid, o_ch, o_y, busy
  );

  modport slave (
    input  ch0_valid, ch0_x, ch1_valid, ch1_x, cfg_we, cfg_addr, cfg_data,
    output ch0_ready, ch1_ready, o_valid, o_ch, o_y, busy
  );

endinterface

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: shared multiply-accumulate datapath.
//   clk   - clock
//   rst   - synchronous active-high reset, clears the accumulator
//   clear - start a new sum (takes priority over en)
//   en    - add a*b to the accumulator this cycle
//   a, b  - signed W-bit operands (sample, coefficient)
//   acc   - registered signed ACC_W-bit running sum
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_sched.sv
// fir_sched: two-channel round-robin scheduler and tap sequencer for a
// 5-tap FIR sharing one multiply-accumulate unit.
//   clk - clock, all state on the rising edge
//   rst - synchronous active-high reset
//   bus - fir_sched_if.slave: channel handshakes, coefficient writes,
//         result strobe/channel/value and busy
// One sample is accepted in IDLE, its channel's history is shifted, then
// N_TAPS MAC cycles and one OUT cycle follow before the next acceptance.
module fir_sched
  import fir_pkg::state_t, fir_pkg::IDLE, fir_pkg::MAC, fir_pkg::OUT, fir_pkg::saturate;
#(
  parameter int N_TAPS = fir_pkg::N_TAPS,
  parameter int W      = fir_pkg::W,
  parameter int SHIFT  = fir_pkg::SHIFT
) (
  input  logic         clk,
  input  logic         rst,
  fir_sched_if.slave   bus
);

  localparam int ACC_W = 2 * W + $clog2(N_TAPS);
  localparam int TAP_W = $clog2(N_TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(N_TAPS - 1);
  localparam logic [2:0]       ADDR_LAST = 3'(N_TAPS - 1);

  state_t                  state;
  logic                    idle;
  logic                    grant;
  logic                    last_grant;
  logic                    cur_ch;
  logic                    ch_hold;
  logic                    hs;
  logic signed [W-1:0]     hs_x;
  logic signed [W-1:0]     y_hold;
  logic signed [W-1:0]     y_sat;
  logic signed [W-1:0]     mac_a;
  logic signed [W-1:0]     mac_b;
  logic [TAP_W-1:0]        tap;
  logic signed [ACC_W-1:0] acc;

  logic signed [W-1:0] hist [2][N_TAPS];
  logic signed [W-1:0] coef [N_TAPS];

  assign idle = (state == IDLE);

  // Round-robin: on a tie the channel that did not win last time is granted.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant = 1'b0;
    if (bus.ch0_valid && bus.ch1_valid) begin
      grant = ~last_grant;
    end else if (bus.ch1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.ch0_ready = idle && !grant;
  assign bus.ch1_ready = idle && grant;

  assign hs   = grant ? (bus.ch1_valid && bus.ch1_ready)
                      : (bus.ch0_valid && bus.ch0_ready);
  assign hs_x = grant ? bus.ch1_x : bus.ch0_x;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      state      <= IDLE;
      tap        <= '0;
      last_grant <= 1'b1;
      cur_ch     <= 1'b0;
      y_hold     <= '0;
      ch_hold    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state      <= MAC;
            tap        <= '0;
            last_grant <= grant;
            cur_ch     <= grant;
          end
        end
        MAC: begin
          tap <= tap + 1'b1;
          if (tap == TAP_LAST) begin
            state <= OUT;
          end
        end
        OUT: begin
          y_hold  <= y_sat;
          ch_hold <= cur_ch;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel sample histories; only the granted channel shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these arrays are architectural state (an aborted run must restart
      // from zero history), so they are reset element by element rather than
      // left as an unreset RAM.
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < N_TAPS; k++) begin
          hist[c][k] <= '0;
        end
      end
    end else if (hs) begin
      hist[grant][0] <= hs_x;
      for (int k = 1; k < N_TAPS; k++) begin
        hist[grant][k] <= hist[grant][k-1];
      end
    end
  end

  // Coefficient bank: pass-through after reset, writable only while idle.
  // A write in the same cycle as a handshake lands before the first MAC cycle,
  // so that sample already sees the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        coef[k] <= '0;
      end
      coef[0] <= W'(1);
    end else if (idle && bus.cfg_we && (bus.cfg_addr <= ADDR_LAST)) begin
      coef[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign mac_a = hist[cur_ch][tap];
  assign mac_b = coef[tap];

  fir_mac_unit u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (hs),
    .en    (state == MAC),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

  assign y_sat = saturate(acc >>> SHIFT);

  // Result is live during OUT and held from the last OUT afterwards.
  assign bus.o_valid = (state == OUT);
  assign bus.o_y     = (state == OUT) ? y_sat  : y_hold;
  assign bus.o_ch    = (state == OUT) ? cur_ch : ch_hold;
  assign bus.busy    = !idle;

endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: directed scoreboard bench for fir_sched. Stimulus tasks push
// the hand-computed result for each accepted sample; a negedge monitor pops
// and compares whenever o_valid is seen.
module tb_fir_sched;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fir_sched_if bus ();

  fir_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit ch;
    int y;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_o_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("o_ch", int'(bus.o_ch), int'(e.ch));
        check("o_y", int'(bus.o_y), e.y);
      end
    end
  end

  task automatic expect_out(input bit ch, input int y);
    exp_t e;
    e.ch = ch;
    e.y  = y;
    sb.push_back(e);
  endtask

  // Offer one sample (optionally with a same-cycle coefficient write) and
  // return 1 ns after the accepting edge.
  task automatic send_cfg(input bit ch, input logic signed [7:0] x,
                          input bit we, input logic [2:0] addr,
                          input logic signed [7:0] data,
                          input bit has_out, input int y);
    bit done = 1'b0;
    if (has_out) expect_out(ch, y);
    @(negedge clk);
    if (ch) begin
      bus.ch1_valid = 1'b1;
      bus.ch1_x     = x;
    end else begin
      bus.ch0_valid = 1'b1;
      bus.ch0_x     = x;
    end
    bus.cfg_we   = we;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if ((ch ? bus.ch1_ready : bus.ch0_ready) === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.ch0_valid = 1'b0;
    bus.ch1_valid = 1'b0;
    bus.cfg_we    = 1'b0;
    if (!done) check("handshake_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic send(input bit ch, input logic signed [7:0] x, input int y);
    send_cfg(ch, x, 1'b0, 3'd0, 8'sd0, 1'b1, y);
    wait_idle();
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic signed [7:0] data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int bc;
    int hsn;
    int nv;
    int ys[6];
    ys = '{1, 100, 2, 127, 3, 127};

    rst           = 1'b1;
    bus.ch0_valid = 1'b0;
    bus.ch0_x     = '0;
    bus.ch1_valid = 1'b0;
    bus.ch1_x     = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_o_valid", int'(bus.o_valid), 0);
    check("rst_o_ch", int'(bus.o_ch), 0);
    check("rst_o_y", int'(bus.o_y), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ch0_ready", int'(bus.ch0_ready), 1);
    check("rst_ch1_ready", int'(bus.ch1_ready), 0);

    // Pass-through defaults: latency and busy length.
    send_cfg(1'b0, 8'sd5, 1'b0, 3'd0, 8'sd0, 1'b1, 5);
    lat = 0;
    bc  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1 && lat == 0) lat = i;
      if (bus.busy === 1'b1) bc++;
      else break;
    end
    check("latency", lat, 6);
    check("busy_cycles", bc, 6);
    @(negedge clk);
    check("hold_o_y", int'(bus.o_y), 5);
    check("hold_o_ch", int'(bus.o_ch), 0);

    // Moving sum on ch0.
    do_reset();
    for (int k = 0; k < 5; k++) cfg_write(3'(k), 8'sd1);
    send(1'b0, 8'sd1, 1);
    send(1'b0, -8'sd6, -5);
    send(1'b0, 8'sd10, 5);
    send(1'b0, 8'sd2, 7);
    send(1'b0, -8'sd4, 3);

    // Both channels requesting continuously: alternating grants.
    do_reset();
    for (int k = 0; k < 5; k++) cfg_write(3'(k), 8'sd1);
    for (int k = 0; k < 6; k++) expect_out(bit'(k % 2), ys[k]);
    @(negedge clk);
    bus.ch0_valid = 1'b1;
    bus.ch0_x     = 8'sd1;
    bus.ch1_valid = 1'b1;
    bus.ch1_x     = 8'sd100;
    hsn = 0;
    for (int c = 0; c < 100 && hsn < 6; c++) begin
      #1;
      if ((bus.ch0_valid && bus.ch0_ready) || (bus.ch1_valid && bus.ch1_ready)) begin
        check("grant_order", int'(bus.ch1_ready), hsn % 2);
        hsn++;
        if (hsn == 6) begin
          @(posedge clk);
          #1;
          bus.ch0_valid = 1'b0;
          bus.ch1_valid = 1'b0;
        end else begin
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (hsn != 6) check("arb_timeout", hsn, 6);
    wait_idle();

    // Negative saturation on ch1.
    do_reset();
    for (int k = 0; k < 5; k++) cfg_write(3'(k), 8'sd127);
    send(1'b1, -8'sd128, -128);
    send(1'b1, -8'sd128, -128);

    // Dropped writes (out-of-range address, write while busy), then a write
    // coinciding with a handshake.
    do_reset();
    cfg_write(3'd5, 8'sd50);
    send(1'b0, 8'sd10, 10);
    send(1'b0, 8'sd20, 20);
    send_cfg(1'b0, 8'sd3, 1'b0, 3'd0, 8'sd0, 1'b1, 3);
    cfg_write(3'd2, 8'sd7);
    wait_idle();
    send(1'b0, 8'sd4, 4);
    send_cfg(1'b0, 8'sd6, 1'b1, 3'd0, 8'sd2, 1'b1, 12);
    wait_idle();

    // Reset in the third MAC cycle aborts the result.
    do_reset();
    send_cfg(1'b0, 8'sd9, 1'b0, 3'd0, 8'sd0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) nv++;
    end
    check("abort_no_o_valid", nv, 0);
    send(1'b0, 8'sd7, 7);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
